// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - core request/response and SRAM signal bundle for mem_bridge
interface mem_bridge_if #(parameter int AW = 20);
   logic [31:0]   a;
   logic [31:0]   o;
   logic          w;
   logic          ce;
   logic [31:0]   i;
   logic [AW-1:0] sram_a;
   logic [7:0]    sram_din;
   logic [7:0]    sram_dout;
   logic          sram_we;

   // bridge side
   modport slave  (input a, o, w, sram_din, output ce, i, sram_a, sram_dout, sram_we);
   // core + SRAM environment side
   modport master (output a, o, w, sram_din, input ce, i, sram_a, sram_dout, sram_we);
endinterface

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - 32-bit core access over 8-bit async SRAM; optional read cache via MEM_BRIDGE_RDCACHE_EN
module mem_bridge #(
   parameter int AW   = 20,
   parameter int WAIT = 0
) (
   input  logic        clock,
   input  logic        reset,
   mem_bridge_if.slave bus
);
   localparam logic [3:0] LP_WAIT = 4'(WAIT);

   typedef enum logic [2:0] {S_LATCH, S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3, S_DONE} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [AW-3:0] r_a_l;
   logic          r_w_l;
   logic [31:0]   r_o_l;
   logic [23:0]   r_asm;
   logic          r_ce;
   logic [31:0]   r_i;
   logic [AW-1:0] r_sram_a;
   logic [7:0]    r_sram_dout;
   logic          r_sram_we;

   logic [1:0]    w_k;
   logic [1:0]    w_k_next;
   state_t        w_next_state;
   logic          w_last;
   logic          w_is_byte;
   logic          w_hit;
   logic [31:0]   w_c_word;
   logic          w_unused;

   // address bits outside the word index are deliberately ignored
   assign w_unused = &{1'b0, bus.a[31:AW], bus.a[1:0]};

   assign w_last       = (r_cnt == LP_WAIT);
   assign w_is_byte    = (r_state == S_BYTE0) || (r_state == S_BYTE1) ||
                         (r_state == S_BYTE2) || (r_state == S_BYTE3);
   assign w_k_next     = w_k + 2'd1;
   assign w_next_state = state_t'(r_state + 3'd1);

   // byte lane index of the current slot
   always_comb begin
      w_k = 2'd0;
      case (r_state)
         S_BYTE1: w_k = 2'd1;
         S_BYTE2: w_k = 2'd2;
         S_BYTE3: w_k = 2'd3;
         default: w_k = 2'd0;
      endcase
   end

`ifdef MEM_BRIDGE_RDCACHE_EN
   logic          r_c_valid;
   logic [AW-3:0] r_c_tag;
   logic [31:0]   r_c_word;

   assign w_hit    = r_c_valid && !bus.w && (bus.a[AW-1:2] == r_c_tag);
   assign w_c_word = r_c_word;

   // one-entry read cache: fill on read completion, drop on a write to the cached word
   always_ff @(posedge clock) begin
      if (reset) begin
         r_c_valid <= 1'b0;
      end else if (r_state == S_LATCH && bus.w && r_c_valid && bus.a[AW-1:2] == r_c_tag) begin
         r_c_valid <= 1'b0;
      end else if (r_state == S_BYTE3 && w_last && !r_w_l) begin
         r_c_valid <= 1'b1;
         r_c_tag   <= r_a_l;
         r_c_word  <= {bus.sram_din, r_asm};
      end
   end
`else
   assign w_hit    = 1'b0;
   assign w_c_word = 32'd0;
`endif

   // access sequencer; every SRAM/core output is registered here so sram_a only moves at slot edges
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_LATCH;
         r_cnt       <= 4'd0;
         r_a_l       <= '0;
         r_w_l       <= 1'b0;
         r_o_l       <= 32'd0;
         r_asm       <= 24'd0;
         r_ce        <= 1'b0;
         r_i         <= 32'd0;
         r_sram_a    <= '0;
         r_sram_dout <= 8'd0;
         r_sram_we   <= 1'b0;
      end else begin
         case (r_state)
            S_LATCH: begin
               r_a_l <= bus.a[AW-1:2];
               r_w_l <= bus.w;
               r_o_l <= bus.o;
               r_cnt <= 4'd0;
               if (w_hit) begin
                  r_state <= S_DONE;
                  r_ce    <= 1'b1;
                  r_i     <= w_c_word;
               end else begin
                  r_state     <= S_BYTE0;
                  r_sram_a    <= {bus.a[AW-1:2], 2'd0};
                  r_sram_dout <= bus.o[7:0];
                  r_sram_we   <= bus.w && (LP_WAIT == 4'd0);
               end
            end
            S_DONE: begin
               r_ce    <= 1'b0;
               r_state <= S_LATCH;
            end
            default: begin
               if (!w_is_byte) begin
                  r_state <= S_LATCH;
               end else if (w_last) begin
                  r_cnt <= 4'd0;
                  if (!r_w_l) begin
                     if (r_state == S_BYTE0) r_asm[7:0]   <= bus.sram_din;
                     if (r_state == S_BYTE1) r_asm[15:8]  <= bus.sram_din;
                     if (r_state == S_BYTE2) r_asm[23:16] <= bus.sram_din;
                  end
                  if (r_state == S_BYTE3) begin
                     r_state   <= S_DONE;
                     r_ce      <= 1'b1;
                     r_sram_we <= 1'b0;
                     if (!r_w_l) r_i <= {bus.sram_din, r_asm};
                  end else begin
                     r_state     <= w_next_state;
                     r_sram_a    <= {r_a_l, w_k_next};
                     r_sram_dout <= r_o_l[{w_k_next, 3'b000} +: 8];
                     r_sram_we   <= r_w_l && (LP_WAIT == 4'd0);
                  end
               end else begin
                  r_cnt     <= r_cnt + 4'd1;
                  r_sram_we <= r_w_l && (r_cnt + 4'd1 == LP_WAIT);
               end
            end
         endcase
      end
   end

   assign bus.ce        = r_ce;
   assign bus.i         = r_i;
   assign bus.sram_a    = r_sram_a;
   assign bus.sram_dout = r_sram_dout;
   assign bus.sram_we   = r_sram_we;
endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed bench for mem_bridge at WAIT=0 and WAIT=2; honours MEM_BRIDGE_RDCACHE_EN
module tb_mem_bridge;
   localparam int AW = 20;
`ifdef MEM_BRIDGE_RDCACHE_EN
   localparam int LAT_HIT = 1;
`else
   localparam int LAT_HIT = 5;
`endif

   logic clock = 1'b0;
   logic reset0;
   logic reset2;
   int   n_chk = 0;
   int   n_err = 0;

   logic [31:0]      q0[$];
   logic [31:0]      q2[$];
   logic [AW+7:0]    wq[$];
   logic [7:0]       mem0 [0:(1<<AW)-1];
   logic [7:0]       mem2 [0:(1<<AW)-1];

   always #5 clock = ~clock;

   mem_bridge_if #(.AW(AW)) bus0 ();
   mem_bridge_if #(.AW(AW)) bus2 ();

   mem_bridge #(.AW(AW), .WAIT(0)) dut0 (.clock(clock), .reset(reset0), .bus(bus0.slave));
   mem_bridge #(.AW(AW), .WAIT(2)) dut2 (.clock(clock), .reset(reset2), .bus(bus2.slave));

   assign bus0.sram_din = mem0[bus0.sram_a];
   assign bus2.sram_din = mem2[bus2.sram_a];

   // asynchronous SRAM models: write on strobe
   always @(posedge clock) if (bus0.sram_we) mem0[bus0.sram_a] <= bus0.sram_dout;
   always @(posedge clock) if (bus2.sram_we) mem2[bus2.sram_a] <= bus2.sram_dout;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // every strobe on the WAIT=2 bridge must match the next expected byte write
   always @(negedge clock) begin
      if (bus2.sram_we === 1'b1) begin
         check("wr_expected", (wq.size() > 0), 1);
         if (wq.size() > 0) check("wr_addr_data", {bus2.sram_a, bus2.sram_dout}, wq.pop_front());
      end
   end

   task automatic check_reset(input string tag, input logic ce, input logic [31:0] i,
                              input logic [AW-1:0] sa, input logic [7:0] sd, input logic we);
      check({tag, "_ce"}, ce, 0);
      check({tag, "_i"}, i, 0);
      check({tag, "_sram_a"}, sa, 0);
      check({tag, "_sram_dout"}, sd, 0);
      check({tag, "_sram_we"}, we, 0);
   endtask

   task automatic access0(input int start, input logic [31:0] a, input logic wr,
                          input logic [31:0] od, input logic [31:0] exp_word, input int exp_lat);
      logic [AW-1:0] prev_a;
      logic [7:0]    odb [4];
      bit            seen;
      seen   = 0;
      prev_a = bus0.sram_a;
      odb[0] = od[7:0]; odb[1] = od[15:8]; odb[2] = od[23:16]; odb[3] = od[31:24];
      bus0.a = a; bus0.w = wr; bus0.o = od;
      q0.push_back(exp_word);
      for (int cyc = start; cyc <= 30 && !seen; cyc++) begin
         @(negedge clock);
         if (exp_lat == 1 && cyc == 1) begin
            check("hit_sram_a", bus0.sram_a, prev_a);
            check("hit_sram_we", bus0.sram_we, 0);
         end else if (exp_lat != 1 && cyc >= 1 && cyc <= 4) begin
            check("w0_sram_a", bus0.sram_a, {a[AW-1:2], 2'(cyc - 1)});
            check("w0_sram_we", bus0.sram_we, wr);
            if (wr) check("w0_sram_dout", bus0.sram_dout, odb[cyc-1]);
         end
         if (bus0.ce) begin
            seen = 1;
            check("w0_ce_cycle", cyc, exp_lat);
            check("w0_i", bus0.i, q0.pop_front());
         end
      end
      check("w0_ce_seen", seen, 1);
   endtask

   task automatic access2(input int start, input logic [31:0] a, input logic wr,
                          input logic [31:0] od, input logic [31:0] exp_word, input int abort_at);
      logic [7:0] odb [4];
      bit         seen;
      bit         aborted;
      seen    = 0;
      aborted = 0;
      odb[0] = od[7:0]; odb[1] = od[15:8]; odb[2] = od[23:16]; odb[3] = od[31:24];
      bus2.a = a; bus2.w = wr; bus2.o = od;
      q2.push_back(exp_word);
      for (int cyc = start; cyc <= 40 && !seen && !aborted; cyc++) begin
         @(negedge clock);
         if (cyc >= 1 && cyc <= 12) begin
            check("w2_sram_a", bus2.sram_a, {a[AW-1:2], 2'((cyc - 1) / 3)});
            check("w2_sram_we", bus2.sram_we, wr && ((cyc - 1) % 3 == 2));
            if (wr) check("w2_sram_dout", bus2.sram_dout, odb[(cyc-1)/3]);
         end
         if (bus2.ce) begin
            seen = 1;
            check("w2_ce_cycle", cyc, 13);
            check("w2_i", bus2.i, q2.pop_front());
         end
         if (cyc == abort_at) begin
            reset2  = 1'b1;
            aborted = 1;
            void'(q2.pop_front());
         end
      end
      if (!aborted) check("w2_ce_seen", seen, 1);
   endtask

   initial begin
      reset0 = 1'b1;
      reset2 = 1'b1;
      bus0.a = 32'h100; bus0.w = 1'b0; bus0.o = 32'd0;
      bus2.a = 32'h204; bus2.w = 1'b1; bus2.o = 32'hDEADBEEF;
      {mem0[32'h100], mem0[32'h101], mem0[32'h102], mem0[32'h103]} = {8'h11, 8'h22, 8'h33, 8'h44};
      {mem0[32'h104], mem0[32'h105], mem0[32'h106], mem0[32'h107]} = {8'h55, 8'h66, 8'h77, 8'h88};
      {mem0[32'h108], mem0[32'h109], mem0[32'h10A], mem0[32'h10B]} = {8'h99, 8'hAA, 8'hBB, 8'hCC};
      {mem0[32'hFFFFC], mem0[32'hFFFFD], mem0[32'hFFFFE], mem0[32'hFFFFF]} = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
      {mem0[32'h0], mem0[32'h1], mem0[32'h2], mem0[32'h3]} = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
      {mem2[32'h302], mem2[32'h303]} = {8'h77, 8'h66};
      repeat (3) @(negedge clock);
      check_reset("rst0", bus0.ce, bus0.i, bus0.sram_a, bus0.sram_dout, bus0.sram_we);
      check_reset("rst2", bus2.ce, bus2.i, bus2.sram_a, bus2.sram_dout, bus2.sram_we);

      // WAIT=0: reads, back-to-back, misaligned, wrap, then cache-sensitive sequence
      reset0 = 1'b0;
      access0(1, 32'h0000_0100, 1'b0, 32'd0, 32'h44332211, 5);
      access0(0, 32'h0000_0104, 1'b0, 32'd0, 32'h88776655, 5);
      access0(0, 32'h0000_010B, 1'b0, 32'd0, 32'hCCBBAA99, 5);
      access0(0, 32'h000F_FFFC, 1'b0, 32'd0, 32'hC4C3C2C1, 5);
      access0(0, 32'hFFF0_0000, 1'b0, 32'd0, 32'hD4D3D2D1, 5);
      access0(0, 32'h0000_0100, 1'b0, 32'd0, 32'h44332211, 5);
      access0(0, 32'h0000_0100, 1'b0, 32'd0, 32'h44332211, LAT_HIT);
      access0(0, 32'h0000_0100, 1'b1, 32'h12345678, 32'h44332211, 5);
      access0(0, 32'h0000_0100, 1'b0, 32'd0, 32'h12345678, 5);
      reset0 = 1'b1;

      // WAIT=2: full write, then a write cut short by reset during BYTE2
      wq.push_back({20'h00204, 8'hEF});
      wq.push_back({20'h00205, 8'hBE});
      wq.push_back({20'h00206, 8'hAD});
      wq.push_back({20'h00207, 8'hDE});
      reset2 = 1'b0;
      access2(1, 32'h0000_0204, 1'b1, 32'hDEADBEEF, 32'h0, 0);
      check("mem_204", {mem2[32'h207], mem2[32'h206], mem2[32'h205], mem2[32'h204]}, 32'hDEADBEEF);
      wq.push_back({20'h00300, 8'h0D});
      wq.push_back({20'h00301, 8'hF0});
      access2(0, 32'h0000_0300, 1'b1, 32'hCAFEF00D, 32'h0, 8);
      @(negedge clock);
      check_reset("midrst", bus2.ce, bus2.i, bus2.sram_a, bus2.sram_dout, bus2.sram_we);
      reset2 = 1'b0;
      access2(1, 32'h0000_0300, 1'b0, 32'd0, 32'h6677F00D, 0);
      check("mem_302_kept", mem2[32'h302], 8'h77);
      check("wq_drained", wq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
